// File: rtl/cla_seq_adder64_pkg.sv
// Shared constants for the sequential CLA adder: slice width and FSM state encoding.
package cla_pkg;

  localparam int SLICE_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/carry_look_ahead_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups chained by group P/G.
module carry_look_ahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [4:0]  c_grp;

  assign g        = a & b;
  assign p        = a ^ b;
  assign c_grp[0] = cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_group
      localparam int B = 4 * gi;
      logic gg;
      logic gp;

      // Carries inside a group are flattened so each depends only on the group carry-in.
      assign c[B]     = c_grp[gi];
      assign c[B + 1] = g[B] | (p[B] & c_grp[gi]);
      assign c[B + 2] = g[B + 1] | (p[B + 1] & g[B]) | (p[B + 1] & p[B] & c_grp[gi]);
      assign c[B + 3] = g[B + 2] | (p[B + 2] & g[B + 1]) | (p[B + 2] & p[B + 1] & g[B])
                      | (p[B + 2] & p[B + 1] & p[B] & c_grp[gi]);

      assign gg = g[B + 3] | (p[B + 3] & g[B + 2]) | (p[B + 3] & p[B + 2] & g[B + 1])
                | (p[B + 3] & p[B + 2] & p[B + 1] & g[B]);
      assign gp = &p[B +: 4];
      assign c_grp[gi + 1] = gg | (gp & c_grp[gi]);
    end
  endgenerate

  assign sum  = p ^ c;
  assign cout = c_grp[4];

endmodule

// File: rtl/cla_seq_adder64.sv
// Multi-cycle WIDTH-bit adder: one 16-bit CLA slice per cycle, LSB chunk first,
// with valid/ready handshakes on operand and result sides.
module cla_seq_adder64
  import cla_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N_SLICES = WIDTH / SLICE;
  localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic             a_msb_reg, a_msb_next;
  logic             b_msb_reg, b_msb_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;

  carry_look_ahead_16bit u_cla (
    .a    (a_reg[SLICE-1:0]),
    .b    (b_reg[SLICE-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    a_msb_next = a_msb_reg;
    b_msb_next = b_msb_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          a_next     = a;
          b_next     = b;
          carry_next = cin;
          a_msb_next = a[WIDTH-1];
          b_msb_next = b[WIDTH-1];
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Each slice result enters at the top, so after N_SLICES shifts chunk 0 sits at the bottom.
        sum_next   = {slice_sum, sum_reg[WIDTH-1:SLICE]};
        a_next     = a_reg >> SLICE;
        b_next     = b_reg >> SLICE;
        carry_next = slice_cout;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(N_SLICES - 1)) begin
          cout_next  = slice_cout;
          ovf_next   = a_msb_reg ^ b_msb_reg ^ slice_sum[SLICE-1] ^ slice_cout;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      a_msb_reg <= a_msb_next;
      b_msb_reg <= b_msb_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Handshake flags come straight from the state register, so no input reaches an output combinationally.
  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_cla_seq_adder64.sv
// Directed-vector bench for cla_seq_adder64 with hand-computed sums, carries and overflow flags.
module tb_cla_seq_adder64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int tests_run = 0;
  int tests_failed = 0;

  cla_seq_adder64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; returns the number of edges it took.
  task automatic wait_out_valid(input int max_cycles, output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < max_cycles) begin
      tick();
      cycles++;
    end
  endtask

  // Full transaction: accept, verify latency and result, then drain the result.
  task automatic do_add(input string tag, input logic [63:0] va, input logic [63:0] vb,
                        input logic vc, input logic [63:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf);
    int lat;
    check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid(20, lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'd4);
    check_eq({tag, "_sum"}, sum, exp_sum);
    check_eq({tag, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
    check_eq({tag, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
    $display("[TB] %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             tag, va, vb, vc, sum, cout, ovf, lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_drain_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    logic [63:0] held_sum;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    tick();
    tick();
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_sum", sum, 64'd0);
    check_eq("rst_cout", {63'd0, cout}, 64'd0);
    check_eq("rst_ovf", {63'd0, ovf}, 64'd0);
    $display("[TB] reset: out_valid=%0d in_ready=%0d sum=%h", out_valid, in_ready, sum);
    rst_n = 1'b1;
    tick();

    do_add("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
    do_add("cross_slice", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    do_add("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_add("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
    do_add("mixed", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1, 1'b0);
    do_add("plain", 64'd100, 64'd23, 1'b0, 64'd123, 1'b0, 1'b0);

    // Backpressure: result 77 held while a new request is presented and must be ignored.
    a = 64'd70; b = 64'd7; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 64'd14; b = 64'd1; cin = 1'b1;
    wait_out_valid(20, lat);
    check_eq("bp_latency", 64'(lat), 64'd4);
    held_sum = 64'd77;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_hold_sum", sum, held_sum);
      check_eq("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      check_eq("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    check_eq("bp_hold_cout", {63'd0, cout}, 64'd0);
    $display("[TB] backpressure: held sum=%h for 10 cycles", sum);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
    check_eq("bp_sum_kept", sum, 64'd77);
    tick();
    in_valid = 1'b0;
    wait_out_valid(20, lat);
    check_eq("bp_second_latency", 64'(lat), 64'd4);
    check_eq("bp_second_sum", sum, 64'd16);
    $display("[TB] backpressure second add: 14+1+1 -> sum=%h", sum);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-operation: accept, run two slices, reset, and confirm nothing escapes.
    a = 64'd999; b = 64'd0; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("midrst_sum", sum, 64'd0);
    for (int i = 0; i < 6; i++) begin
      check_eq("midrst_no_valid", {63'd0, out_valid}, 64'd0);
      tick();
    end
    $display("[TB] mid-op reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);
    do_add("after_rst", 64'd5, 64'd0, 1'b0, 64'd5, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder64.md
Name: cla_seq_adder64

Overview:
- Multi-cycle wide adder built around one carry_look_ahead_16bit slice.
- Adds two WIDTH-bit operands plus carry-in, one SLICE-bit chunk per cycle, LSB chunk first.
- The slice's cout is registered and fed back as the next chunk's cin.
- Sits downstream of the operand/decode logic and consumes the 16-bit CLA's sum/cout.
- Presents a valid/ready handshake on both sides so it can drop into the ALU datapath.

Parameters:
- WIDTH, 64, operand width; must be an integer multiple of SLICE.
- SLICE, 16, chunk width; fixed to the CLA slice width.
- N_SLICES, WIDTH/SLICE (4), derived local constant; not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in_valid  in  1  operands a/b/cin are valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  sum/cout/ovf are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- States: IDLE, RUN, DONE; 2-bit encoding.
- Reset (rst_n=0 at an edge): state=IDLE, slice counter=0, carry reg=0, operand regs=0. Outputs: sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 after that edge.
- Reset mid-RUN or in DONE:
  - Discard the operation and go to IDLE; no partial result is ever flagged valid.
  - Reset has priority over every other event.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: latch a, b, cin into the carry reg; counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the CLA slice gets a_reg[SLICE-1:0], b_reg[SLICE-1:0] and the carry reg.
  - At the edge, slice sum shifts into the MSB end of the sum reg. a_reg/b_reg shift right by SLICE.
  - Carry reg takes the slice cout; counter increments.
  - At the edge where counter==N_SLICES-1:
    - cout takes the slice cout.
    - ovf = a_msb ^ b_msb ^ sum_msb ^ slice cout, where the a/b MSBs are captured at acceptance.
    - Go to DONE.
- Latency: out_valid goes high after edge T+N_SLICES (4 cycles for defaults).
- DONE:
  - out_valid=1; sum/cout/ovf held stable until the handshake completes.
  - out_ready=0 holds indefinitely; no timeout.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle. sum/cout/ovf keep their last values (not cleared).
- Throughput: one operation per N_SLICES+2 cycles with out_ready tied high. No accept during RUN/DONE.
  - in_valid while in_ready=0 is ignored; the upstream must hold its operands.
- Wrap-around:
  - The result is modulo 2^WIDTH; cout carries bit WIDTH.
  - Carry propagation across all slices completes within the N_SLICES cycles (e.g. FFFF..F + 0 + 1).
- Combinational path: limited to one 16-bit CLA per cycle; no path from input ports to output ports.

Decomposition:
- Shared package cla_pkg:
  - SLICE_W=16.
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- Sub-module: carry_look_ahead_16bit, instantiated once, unchanged.
- Control FSM and datapath registers stay in this module; no further split.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles. Expect out_valid=0, in_ready=1, sum=0, cout=0, ovf=0.
- Full ripple:
  - Stimulus: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1.
  - Expect after 4 cycles: sum=0, cout=1, ovf=0, out_valid=1.
- Cross-slice carry:
  - Stimulus: a=64'h0000_0000_0000_FFFF, b=64'h1, cin=0.
  - Expect: sum=64'h0000_0000_0001_0000, cout=0, ovf=0.
- Signed overflow:
  - Stimulus: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0.
  - Expect: sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
  - Stimulus: a=b=64'h8000_0000_0000_0000.
  - Expect: sum=0, cout=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE. Expect sum/cout/ovf stable and in_ready=0.
  - A new in_valid during that time is ignored.
  - Raise out_ready for 1 cycle. Expect in_ready=1 next cycle, then a second add (14+1+1) returns sum=16.
- Reset mid-op:
  - Accept a=999, b=0, cin=1, then pull rst_n low at RUN cycle 2.
  - Expect IDLE, out_valid never asserted, and a subsequent add of 5+0 returns sum=5.
